// File: rtl/aes_stream_ctrl_pkg.sv
// Shared types and constants for the AES stream controller and its watchdog.
package aes_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    WAIT_IN,
    ISSUE,
    PROCESS,
    WRITE_OUT,
    DONE,
    ERR
  } ctrl_state_t;

  // busy covers the whole job, including the DONE cycle, but not ERR
  function automatic logic is_busy_state(input ctrl_state_t s);
    return (s != IDLE) && (s != ERR);
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_watchdog.sv
// Cycle counter bounding how long a block may sit in aes_block before the job errors out.
module aes_watchdog
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c
);

  localparam int unsigned       WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]   LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // saturate at LAST so a stalled controller never wraps back to a safe count
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/aes_stream_ctrl.sv
// Job sequencer in front of aes_block: gates each block on key/RX/TX readiness,
// pulses read_fifo and tx_fifo_write, and reports busy, done and watchdog timeout.
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             mode_in,
  input  logic [CNT_W-1:0] block_count,
  input  logic             key_ready,
  input  logic             rx_fifo_empty,
  input  logic             tx_fifo_full,
  input  logic             aes_data_done,
  input  logic             clear_err,
  output logic             read_fifo,
  output logic             is_encrypt,
  output logic             tx_fifo_write,
  output logic             busy,
  output logic             job_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] blocks_left
);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic             mode_q;
  logic             mode_d;
  logic [CNT_W-1:0] left_q;
  logic [CNT_W-1:0] left_d;
  logic             write_d;

  logic             read_fifo_q;
  logic             tx_fifo_write_q;
  logic             busy_q;
  logic             job_done_q;
  logic             timeout_err_q;

  logic             wd_expired;

  aes_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (state_q == ISSUE),
    .enable_i  (state_q == PROCESS),
    .expired_c (wd_expired)
  );

  // next-state and job-register update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    left_d  = left_q;
    write_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_in;
          left_d  = block_count;
          state_d = (block_count == '0) ? DONE : WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        if (key_ready) begin
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (!rx_fifo_empty) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = PROCESS;
      end
      PROCESS: begin
        // a done arriving on the expiry cycle still completes the block
        if (aes_data_done) begin
          state_d = WRITE_OUT;
        end else if (wd_expired) begin
          state_d = ERR;
        end
      end
      WRITE_OUT: begin
        if (!tx_fifo_full) begin
          write_d = 1'b1;
          if (left_q != '0) begin
            left_d = left_q - CNT_W'(1);
          end
          state_d = (left_q <= CNT_W'(1)) ? DONE : WAIT_IN;
        end
      end
      DONE: begin
        mode_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        if (clear_err) begin
          mode_d  = 1'b0;
          left_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, job registers and Moore outputs all update on the same edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      mode_q          <= 1'b0;
      left_q          <= '0;
      read_fifo_q     <= 1'b0;
      tx_fifo_write_q <= 1'b0;
      busy_q          <= 1'b0;
      job_done_q      <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      left_q          <= left_d;
      read_fifo_q     <= (state_d == ISSUE);
      tx_fifo_write_q <= write_d;
      busy_q          <= is_busy_state(state_d);
      job_done_q      <= (state_d == DONE);
      timeout_err_q   <= (state_d == ERR);
    end
  end

  assign read_fifo     = read_fifo_q;
  assign is_encrypt    = mode_q;
  assign tx_fifo_write = tx_fifo_write_q;
  assign busy          = busy_q;
  assign job_done      = job_done_q;
  assign timeout_err   = timeout_err_q;
  assign blocks_left   = left_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a small aes_block responder model.
module tb_aes_stream_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic             mode_in;
  logic [CNT_W-1:0] block_count;
  logic             key_ready;
  logic             rx_fifo_empty;
  logic             tx_fifo_full;
  logic             aes_data_done = 1'b0;
  logic             clear_err;
  logic             read_fifo;
  logic             is_encrypt;
  logic             tx_fifo_write;
  logic             busy;
  logic             job_done;
  logic             timeout_err;
  logic [CNT_W-1:0] blocks_left;

  int errs   = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int jd_cnt = 0;
  bit aes_en = 1'b0;
  int aes_lat = 10;

  aes_stream_ctrl #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .mode_in       (mode_in),
    .block_count   (block_count),
    .key_ready     (key_ready),
    .rx_fifo_empty (rx_fifo_empty),
    .tx_fifo_full  (tx_fifo_full),
    .aes_data_done (aes_data_done),
    .clear_err     (clear_err),
    .read_fifo     (read_fifo),
    .is_encrypt    (is_encrypt),
    .tx_fifo_write (tx_fifo_write),
    .busy          (busy),
    .job_done      (job_done),
    .timeout_err   (timeout_err),
    .blocks_left   (blocks_left)
  );

  always #5 clk = ~clk;

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (read_fifo === 1'b1)     rd_cnt++;
    if (tx_fifo_write === 1'b1) wr_cnt++;
    if (job_done === 1'b1)      jd_cnt++;
  end

  // aes_block model: done pulse sampled aes_lat edges after the read_fifo edge
  always begin
    @(posedge clk);
    #1;
    if (aes_en && (read_fifo === 1'b1)) begin
      for (int k = 0; k < aes_lat - 1; k++) @(posedge clk);
      #1 aes_data_done = 1'b1;
      @(posedge clk);
      #1 aes_data_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; mode_in = 1'b0; block_count = '0; key_ready = 1'b0;
    rx_fifo_empty = 1'b1; tx_fifo_full = 1'b0; clear_err = 1'b0;
    repeat (2) step();
    checks++;
    if ({read_fifo, is_encrypt, tx_fifo_write, busy, job_done, timeout_err} !== 6'b0) begin
      errs++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {read_fifo, is_encrypt, tx_fifo_write, busy, job_done, timeout_err});
    end
    checks++;
    if (blocks_left !== '0) begin
      errs++; $display("FAIL reset_blocks_left: got %0d expected 0", blocks_left);
    end
    n_rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_multi_block();
    int r0 = rd_cnt, w0 = wr_cnt, j0 = jd_cnt;
    int enc_bad = 0, jd_at = -1;
    logic wr_at_done = 1'b0;
    mode_in = 1'b1; block_count = CNT_W'(3); key_ready = 1'b1; rx_fifo_empty = 1'b0;
    tx_fifo_full = 1'b0; aes_lat = 10; aes_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, is_encrypt} !== 2'b11 || blocks_left !== CNT_W'(3)) begin
      errs++; $display("FAIL multi_capture: busy=%b enc=%b left=%0d expected 1 1 3", busy, is_encrypt, blocks_left);
    end
    for (int i = 1; i <= 300; i++) begin
      step();
      if (busy === 1'b1 && is_encrypt !== 1'b1) enc_bad++;
      if (job_done === 1'b1) begin jd_at = i; wr_at_done = tx_fifo_write; end
      if (busy === 1'b0) break;
    end
    checks++;
    if (jd_at !== 37) begin errs++; $display("FAIL multi_done_cycle: got %0d expected 37", jd_at); end
    checks++;
    if (rd_cnt - r0 !== 3) begin errs++; $display("FAIL multi_reads: got %0d expected 3", rd_cnt - r0); end
    checks++;
    if (wr_cnt - w0 !== 3) begin errs++; $display("FAIL multi_writes: got %0d expected 3", wr_cnt - w0); end
    checks++;
    if (jd_cnt - j0 !== 1) begin errs++; $display("FAIL multi_job_done: got %0d expected 1", jd_cnt - j0); end
    checks++;
    if (enc_bad !== 0) begin errs++; $display("FAIL multi_is_encrypt: %0d busy cycles with enc=0, expected 0", enc_bad); end
    checks++;
    if (wr_at_done !== 1'b1) begin errs++; $display("FAIL multi_last_write_with_done: got %b expected 1", wr_at_done); end
    checks++;
    if (blocks_left !== '0 || is_encrypt !== 1'b0) begin
      errs++; $display("FAIL multi_end_state: left=%0d enc=%b expected 0 0", blocks_left, is_encrypt);
    end
  endtask

  task automatic test_zero_blocks();
    int r0 = rd_cnt, w0 = wr_cnt;
    mode_in = 1'b0; block_count = '0; aes_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({job_done, busy} !== 2'b11) begin
      errs++; $display("FAIL zero_done_pulse: done=%b busy=%b expected 1 1", job_done, busy);
    end
    step();
    checks++;
    if ({job_done, busy} !== 2'b00) begin
      errs++; $display("FAIL zero_back_idle: done=%b busy=%b expected 0 0", job_done, busy);
    end
    repeat (5) step();
    checks++;
    if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) begin
      errs++; $display("FAIL zero_no_traffic: reads=%0d writes=%0d expected 0 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_key_wait();
    int j0 = jd_cnt, early = 0, idle = 0;
    mode_in = 1'b1; block_count = CNT_W'(1); key_ready = 1'b0; rx_fifo_empty = 1'b0; aes_lat = 10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (read_fifo !== 1'b0) early++;
      if (busy !== 1'b1) idle++;
    end
    checks++;
    if (early !== 0 || idle !== 0) begin
      errs++; $display("FAIL key_wait_hold: reads=%0d not_busy=%0d expected 0 0", early, idle);
    end
    key_ready = 1'b1;
    step();
    checks++;
    if (read_fifo !== 1'b0) begin errs++; $display("FAIL key_wait_wait_in: got %b expected 0", read_fifo); end
    step();
    checks++;
    if (read_fifo !== 1'b1) begin errs++; $display("FAIL key_wait_issue: got %b expected 1", read_fifo); end
    key_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy === 1'b0) break;
    end
    checks++;
    if (jd_cnt - j0 !== 1) begin errs++; $display("FAIL key_drop_completes: done=%0d expected 1", jd_cnt - j0); end
    key_ready = 1'b1;
  endtask

  task automatic test_tx_backpressure();
    int w0 = wr_cnt, j0 = jd_cnt, bad = 0;
    mode_in = 1'b1; block_count = CNT_W'(2); tx_fifo_full = 1'b1; aes_lat = 10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 27; i++) begin
      step();
      if (tx_fifo_write !== 1'b0 || blocks_left !== CNT_W'(2)) bad++;
    end
    checks++;
    if (bad !== 0) begin errs++; $display("FAIL tx_stall: %0d cycles wrote or changed count, expected 0", bad); end
    tx_fifo_full = 1'b0;
    step();
    checks++;
    if (tx_fifo_write !== 1'b1 || blocks_left !== CNT_W'(1)) begin
      errs++; $display("FAIL tx_release: wr=%b left=%0d expected 1 1", tx_fifo_write, blocks_left);
    end
    step();
    checks++;
    if (tx_fifo_write !== 1'b0) begin errs++; $display("FAIL tx_single_write: got %b expected 0", tx_fifo_write); end
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy === 1'b0) break;
    end
    checks++;
    if (wr_cnt - w0 !== 2 || jd_cnt - j0 !== 1) begin
      errs++; $display("FAIL tx_job_total: writes=%0d done=%0d expected 2 1", wr_cnt - w0, jd_cnt - j0);
    end
  endtask

  task automatic test_timeout();
    int err_at = -1;
    mode_in = 1'b1; block_count = CNT_W'(2); aes_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    checks++;
    if (read_fifo !== 1'b1) begin errs++; $display("FAIL timeout_issue: got %b expected 1", read_fifo); end
    for (int i = 1; i <= 100; i++) begin
      step();
      if (timeout_err === 1'b1) begin err_at = i; break; end
    end
    checks++;
    if (err_at !== 65) begin errs++; $display("FAIL timeout_cycle: got %0d expected 65", err_at); end
    checks++;
    if ({busy, read_fifo, tx_fifo_write} !== 3'b000 || blocks_left !== CNT_W'(2)) begin
      errs++; $display("FAIL timeout_err_outputs: busy/rd/wr=%b left=%0d expected 000 2",
                       {busy, read_fifo, tx_fifo_write}, blocks_left);
    end
    mode_in = 1'b0; block_count = CNT_W'(5); start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || blocks_left !== CNT_W'(2)) begin
      errs++; $display("FAIL timeout_start_ignored: err=%b busy=%b left=%0d expected 1 0 2",
                       timeout_err, busy, blocks_left);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    checks++;
    if ({timeout_err, busy} !== 2'b00 || blocks_left !== '0) begin
      errs++; $display("FAIL timeout_clear: err=%b busy=%b left=%0d expected 0 0 0", timeout_err, busy, blocks_left);
    end
    aes_en = 1'b1;
  endtask

  task automatic test_done_at_expiry();
    int w0 = wr_cnt, j0 = jd_cnt, saw_err = 0;
    mode_in = 1'b1; block_count = CNT_W'(1); aes_lat = 65; aes_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (timeout_err === 1'b1) saw_err++;
      if (busy === 1'b0) break;
    end
    checks++;
    if (saw_err !== 0 || wr_cnt - w0 !== 1 || jd_cnt - j0 !== 1) begin
      errs++; $display("FAIL done_wins_expiry: err_cycles=%0d writes=%0d done=%0d expected 0 1 1",
                       saw_err, wr_cnt - w0, jd_cnt - j0);
    end
    aes_lat = 10;
  endtask

  task automatic test_reset_mid_job();
    int r0 = rd_cnt, w0 = wr_cnt, j0 = 0, enc_bad = 0;
    mode_in = 1'b1; block_count = CNT_W'(5); aes_lat = 10; aes_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    checks++;
    if (busy !== 1'b1 || blocks_left !== CNT_W'(5)) begin
      errs++; $display("FAIL midrst_pre: busy=%b left=%0d expected 1 5", busy, blocks_left);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({read_fifo, is_encrypt, tx_fifo_write, busy, job_done, timeout_err} !== 6'b0 || blocks_left !== '0) begin
      errs++; $display("FAIL midrst_async: outs=%b left=%0d expected 000000 0",
                       {read_fifo, is_encrypt, tx_fifo_write, busy, job_done, timeout_err}, blocks_left);
    end
    repeat (2) step();
    n_rst = 1'b1;
    repeat (12) step();
    checks++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 1) begin
      errs++; $display("FAIL midrst_discard: writes=%0d reads=%0d expected 0 1", wr_cnt - w0, rd_cnt - r0);
    end
    r0 = rd_cnt; w0 = wr_cnt; j0 = jd_cnt;
    mode_in = 1'b1; block_count = CNT_W'(2);
    start = 1'b1;
    step();
    mode_in = 1'b0; block_count = CNT_W'(7);
    repeat (3) step();
    start = 1'b0;
    checks++;
    if (is_encrypt !== 1'b1 || blocks_left !== CNT_W'(2)) begin
      errs++; $display("FAIL midjob_start_ignored: enc=%b left=%0d expected 1 2", is_encrypt, blocks_left);
    end
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy === 1'b1 && is_encrypt !== 1'b1) enc_bad++;
      if (busy === 1'b0) break;
    end
    checks++;
    if (rd_cnt - r0 !== 2 || wr_cnt - w0 !== 2 || jd_cnt - j0 !== 1 || enc_bad !== 0) begin
      errs++; $display("FAIL postrst_job: reads=%0d writes=%0d done=%0d enc_bad=%0d expected 2 2 1 0",
                       rd_cnt - r0, wr_cnt - w0, jd_cnt - j0, enc_bad);
    end
  endtask

  initial begin
    test_reset();
    test_multi_block();
    test_zero_blocks();
    test_key_wait();
    test_tx_backpressure();
    test_timeout();
    test_done_at_expiry();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
